// File: rtl/crash_course_io_out_serializer.sv
// Captures 16-byte CPU output frames into a small buffer and drains them as a
// valid/ready byte stream with an idle gap between frames.
// Optional: CRASH_COURSE_IO_SERIALIZER_DROP_COUNT_EN enables the drop counter.
module crash_course_io_out_serializer #(
  parameter int unsigned FRAME_DEPTH = 2,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                               clk,
  input  logic                               async_rst_n,
  input  logic                               clk_en,
  input  logic [15:0][7:0]                   io_out,
  input  logic                               io_write_en,
  output logic                               io_write_stall,
  output logic                               byte_valid,
  input  logic                               byte_ready,
  output logic [7:0]                         byte_data,
  output logic                               byte_last,
  output logic [$clog2(FRAME_DEPTH):0]       frames_pending,
  output logic [7:0]                         drop_count
);

  localparam int unsigned PTR_W = $clog2(FRAME_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [GAP_W-1:0]       gap_cnt, gap_nxt;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       pending;
  logic [3:0]             byte_idx;
  logic [15:0][7:0]       mem [FRAME_DEPTH];

  logic full, capture, xfer, pop;

  assign full           = (pending == CNT_W'(FRAME_DEPTH));
  assign capture        = clk_en & io_write_en & ~full;
  assign byte_valid     = (state == STREAM);
  assign xfer           = clk_en & byte_valid & byte_ready;
  assign pop            = xfer & (byte_idx == 4'd15);
  assign io_write_stall = full;
  assign frames_pending = pending;
  assign byte_data      = byte_valid ? mem[rd_ptr][byte_idx] : 8'd0;
  assign byte_last      = byte_valid & (byte_idx == 4'd15);

  // State and gap counter register
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // Next-state: a capture in IDLE starts streaming on the same edge
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    if (clk_en) begin
      case (state)
        IDLE: begin
          if ((pending != '0) || capture) state_nxt = STREAM;
        end
        STREAM: begin
          if (pop) begin
            gap_nxt   = GAP_W'(GAP_CYCLES);
            state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          gap_nxt = gap_cnt - GAP_W'(1);
          if (gap_cnt <= GAP_W'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Buffer pointers, occupancy and byte index
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pending  <= '0;
      byte_idx <= '0;
    end else if (clk_en) begin
      if (capture) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({capture, pop})
        2'b10:   pending <= pending + CNT_W'(1);
        2'b01:   pending <= pending - CNT_W'(1);
        default: pending <= pending;
      endcase
      if (xfer) byte_idx <= byte_idx + 4'd1;
    end
  end

  // Frame storage needs no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= io_out;
  end

`ifdef CRASH_COURSE_IO_SERIALIZER_DROP_COUNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      drop_q <= '0;
    end else if (clk_en && io_write_en && full && (drop_q != 8'hff)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 8'd0;
`endif

endmodule
